mult_arbiter: RTL and testbench

//  Shares one combinational W x W unsigned carry-save multiplier (instantiated outside

---
 rtl/mult_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end for one shared combinational W x W multiplier. A winning requester's
// operands are launched, held for LAT settle cycles, and then the product is captured and returned.
module mult_arbiter #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*W-1:0]         req_x,
    input  logic [N*W-1:0]         req_y,
    output logic [W-1:0]           mul_x,
    output logic [W-1:0]           mul_y,
    input  logic [2*W-1:0]         mul_p,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [$clog2(N)-1:0]   rsp_id,
    output logic [2*W-1:0]         rsp_p
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]    mul_x_reg, mul_x_next;
    logic [W-1:0]    mul_y_reg, mul_y_next;
    logic [IW-1:0]   rsp_id_reg, rsp_id_next;
    logic [2*W-1:0]  rsp_p_reg, rsp_p_next;

    logic [W-1:0]    x_arr [N];
    logic [W-1:0]    y_arr [N];
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    int              idx;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*W +: W];
            assign y_arr[gi] = req_y[gi*W +: W];
        end
    endgenerate

    // Rotating-priority search starting at ptr, wrapping modulo N (N need not be a power of two).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && req_valid[IW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        mul_x_next  = mul_x_reg;
        mul_y_next  = mul_y_reg;
        rsp_id_next = rsp_id_reg;
        rsp_p_next  = rsp_p_reg;
        req_ready   = '0;
        rsp_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    req_ready   = N'(1) << grant_idx;
                    mul_x_next  = x_arr[grant_idx];
                    mul_y_next  = y_arr[grant_idx];
                    rsp_id_next = grant_idx;
                    cnt_next    = CW'(LAT);
                    state_next  = CALC;
                end
            end
            CALC: begin
                // Product is sampled on the last settle cycle; operands stay frozen until then.
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    rsp_p_next = mul_p;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    ptr_next   = (rsp_id_reg == IW'(N - 1)) ? '0 : rsp_id_reg + 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            mul_x_reg  <= '0;
            mul_y_reg  <= '0;
            rsp_id_reg <= '0;
            rsp_p_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            mul_x_reg  <= mul_x_next;
            mul_y_reg  <= mul_y_next;
            rsp_id_reg <= rsp_id_next;
            rsp_p_reg  <= rsp_p_next;
        end
    end

    assign mul_x  = mul_x_reg;
    assign mul_y  = mul_y_reg;
    assign rsp_id = rsp_id_reg;
    assign rsp_p  = rsp_p_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized checks of mult_arbiter against a transaction-level reference model;
// the shared multiplier is modelled here as a plain combinational product.
module tb_mult_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IW  = $clog2(N);

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_x;
    logic [N*W-1:0]     req_y;
    logic [W-1:0]       mul_x;
    logic [W-1:0]       mul_y;
    logic [2*W-1:0]     mul_p;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [2*W-1:0]     rsp_p;

    logic [W-1:0]       x_arr [N];
    logic [W-1:0]       y_arr [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign req_x[gi*W +: W] = x_arr[gi];
            assign req_y[gi*W +: W] = y_arr[gi];
        end
    endgenerate

    assign mul_p = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};

    mult_arbiter #(.W(W), .N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // One complete transaction: request, expected grant, latency, optional backpressure, accept.
    task automatic run_op(input logic [N-1:0] vset, input int g, input int bp);
        logic [63:0] ep;
        int waited;
        ep = prod(x_arr[g], y_arr[g]);
        req_valid = vset;
        rsp_ready = 1'b0;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            step();
            #1;
            waited++;
        end
        check("grant", 64'(req_ready), 64'(1 << g));
        step();
        req_valid[g] = 1'b0;
        #1;
        check("mul_x", 64'(mul_x), 64'(x_arr[g]));
        check("mul_y", 64'(mul_y), 64'(y_arr[g]));
        for (int k = 1; k <= LAT; k++) begin
            check("early_rsp", 64'(rsp_valid), 64'(0));
            check("calc_ready", 64'(req_ready), 64'(0));
            step();
            #1;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_p", rsp_p, ep);
        check("rsp_id", 64'(rsp_id), 64'(g));
        for (int k = 0; k < bp; k++) begin
            step();
            #1;
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_p", rsp_p, ep);
            check("bp_id", 64'(rsp_id), 64'(g));
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_mul_x", 64'(mul_x), 64'(x_arr[g]));
            check("bp_mul_y", 64'(mul_y), 64'(y_arr[g]));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        $display("txn id=%0d x=%0h y=%0h p=%0h", g, x_arr[g], y_arr[g], ep);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, rsps, last_cyc;
        int rr, busy, acc_cyc, exp_id, g, took;
        logic [63:0] exp_p;
        logic [N-1:0] exp_ready;
        logic exp_rv;

        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_arr[i] = '0;
            y_arr[i] = '0;
        end
        @(negedge clk);
        step();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_p", rsp_p, 64'(0));
        check("rst_mul_x", 64'(mul_x), 64'(0));
        check("rst_mul_y", 64'(mul_y), 64'(0));
        reset = 1'b0;
        step();

        // Single request from requester 1
        x_arr[1] = 32'd3;
        y_arr[1] = 32'd5;
        run_op(4'b0010, 1, 0);
        check("single_p15", rsp_p, 64'd15);

        // All requesters continuously valid from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_arr[i] = W'(i + 1);
            y_arr[i] = W'(100 + 7 * i);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        grants = 0;
        rsps = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
            if (req_ready != '0) begin
                check("rr_order", 64'(req_ready), 64'(1 << (grants % N)));
                if (grants > 0) begin
                    check("rr_spacing", 64'(cyc - last_cyc), 64'(LAT + 2));
                end
                last_cyc = cyc;
                grants++;
            end
            if (rsp_valid) begin
                check("rr_rsp_id", 64'(rsp_id), 64'(rsps % N));
                check("rr_rsp_p", rsp_p, prod(x_arr[rsps % N], y_arr[rsps % N]));
                rsps++;
            end
            step();
            #1;
        end
        check("rr_grant_count", 64'(grants), 64'(5));
        req_valid = '0;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
        end
        rsp_ready = 1'b0;
        #1;
        check("rr_drained", 64'(rsp_valid), 64'(0));

        // Maximum operands (pointer now at 1, only requester 2 valid)
        x_arr[2] = 32'hFFFF_FFFF;
        y_arr[2] = 32'hFFFF_FFFF;
        run_op(4'b0100, 2, 0);
        check("max_p", rsp_p, 64'hFFFF_FFFE_0000_0001);

        // Backpressure with requester 1 still waiting (pointer at 3)
        x_arr[3] = 32'h1234_5678;
        y_arr[3] = 32'h0000_9ABC;
        run_op(4'b1010, 3, 5);

        // Wrap: after grant 3, requesters 0 and 3 valid -> 0 then 3
        x_arr[0] = 32'd77;
        y_arr[0] = 32'd11;
        run_op(4'b1001, 0, 0);
        run_op(4'b1000, 3, 0);

        // Reset during CALC
        run_op(4'b0010, 1, 0);
        req_valid = 4'b0100;
        #1;
        check("pre_rst_grant", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        reset = 1'b1;
        step();
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_rst_rsp_p", rsp_p, 64'(0));
        check("mid_rst_mul_x", 64'(mul_x), 64'(0));
        check("mid_rst_mul_y", 64'(mul_y), 64'(0));
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            step();
            #1;
            check("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
        end
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'(4'b0001));

        // Randomized traffic against a transaction-level model
        req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rr = 0;
        busy = 0;
        acc_cyc = 0;
        exp_id = 0;
        exp_p = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    x_arr[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : W'($urandom);
                    y_arr[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : W'($urandom);
                end else if (req_valid[i] && busy != 0 && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = '0;
            g = -1;
            if (busy == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(rr + k) % N]) begin
                        g = (rr + k) % N;
                    end
                end
                if (g >= 0) begin
                    exp_ready = N'(1) << g;
                end
            end
            exp_rv = (busy != 0) && (cyc - acc_cyc >= LAT + 1);
            check("rand_ready", 64'(req_ready), 64'(exp_ready));
            check("rand_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) begin
                check("rand_id", 64'(rsp_id), 64'(exp_id));
                check("rand_p", rsp_p, exp_p);
            end
            took = 0;
            if (g >= 0) begin
                busy = 1;
                acc_cyc = cyc;
                exp_id = g;
                exp_p = prod(x_arr[g], y_arr[g]);
                took = 1;
            end else if (exp_rv && rsp_ready) begin
                busy = 0;
                rr = (exp_id + 1) % N;
                $display("txn id=%0d p=%0h cyc=%0d", exp_id, exp_p, cyc);
            end
            step();
            if (took != 0) begin
                req_valid[exp_id] = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
